tt_mux_sel_ctrl: RTL and testbench

- Sequencing controller for the project multiplexer's control chain.
- Accepts a "select project N" or "disable" request. It then drives the mux control lines (select-reset, select-increment, enable) and the selected project's reset in the order and with the timing the mux requires.
- Sits between the management front-end (SPI/pins) and the mux control inputs. It is the only driver of those lines.

---
 rtl/tt_mux_pkg.sv | 7 +
 rtl/tt_mux_dncnt.sv | 18 +
 rtl/tt_mux_sel_ctrl.sv | 93 +++++++++
 tb/tb_tt_mux_sel_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/tt_mux_pkg.sv
// tt_mux_pkg: shared state encoding and default sizing for the project mux control chain.
package tt_mux_pkg;
  typedef enum logic [2:0] {IDLE, SEL_RST, INC_HI, INC_LO, ENA_HOLD} state_t;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_RST_HOLD = 4;
  localparam int DEF_URST_CYC = 8;
endpackage

// File: rtl/tt_mux_dncnt.sv
// tt_mux_dncnt: loadable down-counter that saturates at zero and flags it.
module tt_mux_dncnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/tt_mux_sel_ctrl.sv
// tt_mux_sel_ctrl: sequences select-chain reset, increment pulses, enable and user reset
// so the mux lands on the requested project (or is left disabled).
module tt_mux_sel_ctrl
  import tt_mux_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RST_HOLD = DEF_RST_HOLD,
  parameter int URST_CYC = DEF_URST_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_off,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              cur_valid,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              user_rst_n
);
  localparam int TMAX = RST_HOLD > URST_CYC ? RST_HOLD : URST_CYC;
  localparam int TW = $clog2(TMAX) + 1;
  state_t state, state_n;
  logic [ADDR_W-1:0] tgt, rem;
  logic [TW-1:0] tmr_unused;
  logic off_q, t_zero, r_zero, accept, enter_ena, fin_sel, fin_off;
  logic sel_rst_n_n, ena_n, urst_n_n;
  assign accept = req_valid && state == IDLE;
  tt_mux_dncnt #(.W(TW)) u_tmr (
    .clk(clk), .rst(rst),
    .load(accept || enter_ena),
    .val(accept ? TW'(RST_HOLD - 1) : TW'(URST_CYC - 1)),
    .dec(state == SEL_RST || state == ENA_HOLD),
    .cnt(tmr_unused), .zero(t_zero)
  );
  tt_mux_dncnt #(.W(ADDR_W)) u_rem (
    .clk(clk), .rst(rst),
    .load(accept), .val(req_addr),
    .dec(state == INC_LO),
    .cnt(rem), .zero(r_zero)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = accept ? SEL_RST : IDLE;
      SEL_RST:  state_n = !t_zero ? SEL_RST : off_q ? IDLE : r_zero ? ENA_HOLD : INC_HI;
      INC_HI:   state_n = INC_LO;
      INC_LO:   state_n = rem == ADDR_W'(1) ? ENA_HOLD : INC_HI;
      ENA_HOLD: state_n = t_zero ? IDLE : ENA_HOLD;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    enter_ena   = state != ENA_HOLD && state_n == ENA_HOLD;
    fin_sel     = state == ENA_HOLD && t_zero;
    fin_off     = state == SEL_RST && t_zero && off_q;
    sel_rst_n_n = accept ? 1'b0 : (state == SEL_RST && t_zero) ? 1'b1 : ctrl_sel_rst_n;
    ena_n       = accept ? 1'b0 : enter_ena ? 1'b1 : ctrl_ena;
    urst_n_n    = accept ? 1'b0 : fin_sel ? 1'b1 : user_rst_n;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      off_q          <= 1'b0;
      tgt            <= '0;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      cur_valid      <= 1'b0;
      cur_addr       <= '0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      user_rst_n     <= 1'b0;
    end else begin
      state          <= state_n;
      off_q          <= accept ? req_off : off_q;
      tgt            <= accept ? req_addr : tgt;
      req_ready      <= state_n == IDLE;
      busy           <= state_n != IDLE;
      done           <= fin_sel || fin_off;
      cur_valid      <= accept ? 1'b0 : fin_sel ? 1'b1 : cur_valid;
      cur_addr       <= fin_sel ? tgt : cur_addr;
      ctrl_sel_rst_n <= sel_rst_n_n;
      ctrl_sel_inc   <= state_n == INC_HI;
      ctrl_ena       <= ena_n;
      user_rst_n     <= urst_n_n;
    end
endmodule

// File: tb/tb_tt_mux_sel_ctrl.sv
// tb_tt_mux_sel_ctrl: randomized requests checked against a latency/pulse-count model of the mux sequence.
module tb_tt_mux_sel_ctrl;
  localparam int AW = 10;
  localparam int RH = 4;
  localparam int UC = 8;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_off = 0;
  logic [AW-1:0] req_addr = '0;
  logic req_ready, busy, done, cur_valid, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, user_rst_n;
  logic [AW-1:0] cur_addr;
  int n_tests = 0, n_fail = 0;
  bit m_valid = 0;
  int m_addr = 0;
  always #5 clk = ~clk;
  tt_mux_sel_ctrl #(.ADDR_W(AW), .RST_HOLD(RH), .URST_CYC(UC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_off(req_off), .req_addr(req_addr),
    .req_ready(req_ready), .busy(busy), .done(done), .cur_valid(cur_valid), .cur_addr(cur_addr),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena),
    .user_rst_n(user_rst_n)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cv"}, cur_valid, 0);
    chk({tag, "_ca"}, cur_addr, 0);
    chk({tag, "_srst"}, ctrl_sel_rst_n, 0);
    chk({tag, "_inc"}, ctrl_sel_inc, 0);
    chk({tag, "_ena"}, ctrl_ena, 0);
    chk({tag, "_urst"}, user_rst_n, 0);
  endtask
  task automatic run_req(input bit off, input int addr, input bit inject);
    int k = 0, n_srst = 0, n_inc = 0, n_urst = 0, viol = 0;
    int exp_lat = off ? RH : RH + 2 * addr + UC;
    int exp_inc = off ? 0 : addr;
    bit seen = 0, injected = 0;
    @(negedge clk);
    req_valid = 1; req_off = off; req_addr = AW'(addr);
    chk("ready_pre", req_ready, 1);
    @(negedge clk);
    req_valid = 0; req_off = 1'($urandom); req_addr = AW'($urandom);
    chk("ena_drop", ctrl_ena, 0);
    chk("urst_drop", user_rst_n, 0);
    chk("cv_drop", cur_valid, 0);
    while (!seen && k < 5000) begin
      if (done) seen = 1;
      else begin
        if (!busy || req_ready) viol++;
        if (!ctrl_sel_rst_n) n_srst++;
        if (ctrl_sel_inc) n_inc++;
        if (ctrl_ena && !user_rst_n) n_urst++;
        if (ctrl_sel_inc && (!ctrl_sel_rst_n || ctrl_ena)) viol++;
        if (ctrl_ena && n_inc < exp_inc) viol++;
        if (inject && ctrl_sel_inc && !injected) begin
          req_valid = 1; req_off = 0; req_addr = AW'(addr + 3); injected = 1;
        end else req_valid = 0;
        @(negedge clk);
        k++;
      end
    end
    req_valid = 0;
    chk("timeout", seen, 1);
    chk("latency", k, exp_lat);
    chk("srst_cycles", n_srst, RH);
    chk("inc_pulses", n_inc, exp_inc);
    chk("urst_cycles", n_urst, off ? 0 : UC);
    chk("invariants", viol, 0);
    chk("busy_end", busy, 0);
    chk("ready_end", req_ready, 1);
    if (!off) begin m_valid = 1; m_addr = addr; end
    else m_valid = 0;
    chk("cur_valid", cur_valid, m_valid);
    chk("cur_addr", cur_addr, m_addr);
    chk("ena_end", ctrl_ena, !off);
    chk("urst_end", user_rst_n, !off);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  task automatic reset_mid;
    int k = 0;
    bit seen_inc = 0;
    @(negedge clk);
    req_valid = 1; req_off = 0; req_addr = AW'(7);
    @(negedge clk);
    req_valid = 0;
    while (!(seen_inc && !ctrl_sel_inc) && k < 100) begin
      if (ctrl_sel_inc) seen_inc = 1;
      @(negedge clk);
      k++;
    end
    chk("reach_inc_lo", seen_inc, 1);
    #2 rst = 1;
    #1 chk_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) chk("no_done_after_rst", {done, busy}, 0);
    end
    m_valid = 0; m_addr = 0;
    chk("rst_cur_valid", cur_valid, 0);
    run_req(0, 2, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("in_rst");
    rst = 0;
    @(negedge clk);
    chk_reset_vals("idle");
    run_req(0, 3, 0);
    run_req(0, 0, 0);
    run_req(0, 5, 0);
    run_req(0, 1, 0);
    run_req(1, 0, 0);
    run_req(0, 6, 1);
    reset_mid();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(3)) @(negedge clk);
      run_req($urandom_range(3) == 0, $urandom_range(20), 1'($urandom));
    end
    run_req(0, (1 << AW) - 1, 0);
    run_req(1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
